// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus request/response types, arbiter state encoding and muted-bus constants.
package dbus_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } dbus_arb_state_t;

    localparam dbus_req_t  DBUS_REQ_ZERO  = '0;
    localparam dbus_resp_t DBUS_RESP_ZERO = '0;

    function automatic dbus_arb_state_t own_state(input logic port);
        return port ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/dbus_arb_pick.sv
// Combinational two-way winner select; prio_i names the port that takes a tie.
module dbus_arb_pick (
    input  logic valid_0_i,
    input  logic valid_1_i,
    input  logic prio_i,
    output logic grant_valid_o,
    output logic grant_o
);

    assign grant_valid_o = valid_0_i | valid_1_i;
    assign grant_o       = (valid_0_i & valid_1_i) ? prio_i : valid_1_i;

endmodule

// File: rtl/dbus_arbiter.sv
// Two-to-one data-bus arbiter holding ownership until data_ok.
// DBUS_ARB_RR_EN selects round-robin ties; otherwise FIXED_PRIO_PORT always wins.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO_PORT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  dbus_req_t  dreq_0,
    output dbus_resp_t dresp_0,
    input  dbus_req_t  dreq_1,
    output dbus_resp_t dresp_1,
    output dbus_req_t  dreq,
    input  dbus_resp_t dresp,
    output logic       owner,
    output logic       busy
);

    dbus_arb_state_t state_q, state_d;
    logic            owner_q, owner_d;
    logic            prio;

`ifdef DBUS_ARB_RR_EN
    logic ptr_q, ptr_d;
    assign prio = ptr_q;
`else
    assign prio = (FIXED_PRIO_PORT != 0);
`endif

    logic grant_valid, grant;

    dbus_arb_pick u_pick (
        .valid_0_i     (dreq_0.valid),
        .valid_1_i     (dreq_1.valid),
        .prio_i        (prio),
        .grant_valid_o (grant_valid),
        .grant_o       (grant)
    );

    logic idle, active, sel, done;

    // Reset gates active so the bus and both responses go quiet asynchronously.
    assign idle   = (state_q == IDLE);
    assign active = rst & (~idle | grant_valid);
    assign sel    = idle ? grant : (state_q == OWN1);
    assign done   = active & dresp.data_ok;

    assign dreq    = active ? (sel ? dreq_1 : dreq_0) : DBUS_REQ_ZERO;
    assign dresp_0 = (active & ~sel) ? dresp : DBUS_RESP_ZERO;
    assign dresp_1 = (active &  sel) ? dresp : DBUS_RESP_ZERO;
    assign owner   = rst & ((idle & grant_valid) ? grant : owner_q);
    assign busy    = active;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (active) begin
            owner_d = sel;
            state_d = done ? IDLE : own_state(sel);
        end
    end

`ifdef DBUS_ARB_RR_EN
    assign ptr_d = done ? ~sel : ptr_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
`ifdef DBUS_ARB_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifdef DBUS_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

`ifndef SYNTHESIS
    // An owner must hold valid until its data_ok; dropping it early is a master bug.
    always @(posedge clk) begin
        if (rst && state_q == OWN0)
            assert (dreq_0.valid) else $error("dbus_arbiter: port 0 dropped valid while owning the bus");
        if (rst && state_q == OWN1)
            assert (dreq_1.valid) else $error("dbus_arbiter: port 1 dropped valid while owning the bus");
    end
`endif

endmodule
